rop3_mode_infer: RTL and testbench
==================================

Name: rop3_mode_infer

Overview:
- Inverse companion of the ROP3 raster-op unit: observes streamed (P, S, D, Result) bit-vector samples and reconstructs the 8-bit ROP3 mode code (truth table) that produced them.
- Sits on the verification/trace side of the raster pipeline.
- Reports the inferred mode, which truth-table entries were observed, whether the samples were self-consistent, and whether the mode is one of the 15 supported modes.

Parameters:
- N, 8, bit width of P, S, D, Result (N >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  sample beat valid
- in_ready  output  1  block can accept a beat
- in_last  input  1  beat closes the current frame
- P  input  N  pattern bits of sample
- S  input  N  source bits of sample
- D  input  N  destination bits of sample
- R  input  N  Result bits of sample
- out_valid  output  1  inference report valid
- out_ready  input  1  consumer accepts report
- out_mode  output  8  inferred mode; unobserved entries read 0
- out_known  output  8  bit k = truth-table entry k observed
- out_conflict  output  1  contradictory samples seen in frame
- out_supported  output  1  out_known==8'hFF, no conflict, mode in supported set

Behaviour:
- Truth-table index for bit i: idx = {P[i], S[i], D[i]}, with P as the MSB (weight 4), S weight 2, D weight 1. Entry idx takes value R[i].
- Supported set: 00, 11, 33, 44, 55, 5A, 66, 88, BB, C0, CC, EE, F0, FB, FF (hex).
- FSM has two states:
  - ACC: in_ready=1, out_valid=0.
  - REPORT: in_ready=0, out_valid=1.
- Beat acceptance: a beat is accepted on a rising edge with in_valid & in_ready. Per beat, compute:
  - seen1[k] = OR of (idx==k & R[i]) over all i.
  - seen0[k] = OR of (idx==k & ~R[i]) over all i.
- Register update on an accepted beat:
  - known <= known | seen0 | seen1.
  - val[k] <= known[k] ? val[k] : seen1[k].
  - conflict <= conflict | OR over k of (seen0[k]&seen1[k] | known[k]&val[k]&seen0[k] | known[k]&~val[k]&seen1[k]).
  - Conflict is sticky within the frame.
- Accepted beat with in_last=1:
  - The beat's own contribution is merged.
  - State moves to REPORT on the same edge.
  - Outputs become valid in the next cycle (1-cycle latency).
  - out_mode = val & known.
  - out_known = known.
  - out_conflict and out_supported are registered together with the report.
- Zero-beat frames are impossible; a frame is at least one beat.
- In REPORT, all out_* are held stable while out_ready=0. Inputs are ignored.
- When out_valid & out_ready:
  - known, val and conflict clear.
  - out_valid drops.
  - State returns to ACC; in_ready=1 in the next cycle. There is no same-cycle re-accept.
- Unsupported but complete mode (e.g. 3C): out_supported=0, out_conflict=0, out_mode reports the code.
- Conflict: out_mode still reports first-seen values and out_supported=0.
- Reset:
  - State ACC; in_ready=1 in the first cycle after reset.
  - known=0, val=0, conflict=0.
  - out_valid=0, out_mode=0, out_known=0, out_conflict=0, out_supported=0.
- Reset mid-frame or mid-report discards all partial state. A beat presented in the reset cycle is not accepted.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Single beat, N=8: P=F0, S=CC, D=AA, R=5A, in_last=1 -> next cycle out_valid=1, out_mode=5A, out_known=FF, out_conflict=0, out_supported=1.
2. Same P/S/D with R=3C, in_last=1 -> out_mode=3C, out_known=FF, out_supported=0, out_conflict=0.
3. Partial then completing, each beat followed by out_ready=1:
   - Beat P=00, S=00, D=00, R=FF, last=1 -> out_known=01, out_mode=01, out_supported=0.
   - Second frame, beat 1: P=F0, S=CC, D=AA, R=88, last=0; beat 2: P=00, S=00, D=00, R=00, last=1 -> out_mode=88, out_supported=1.
4. Conflict:
   - Beat 1: P=S=D=00, R=00, last=0; beat 2: P=S=D=00, R=01, last=1 -> out_conflict=1, out_mode=00, out_known=01, out_supported=0.
   - Also a single beat with P=S=D=00, R=0F, last=1 -> out_conflict=1.
5. Backpressure: after case 1, hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 throughout and outputs unchanged. Then out_ready=1 -> next cycle out_valid=0, in_ready=1, and the held beat is accepted afterwards.
6. Reset mid-frame: accept P=F0, S=CC, D=AA, R=FF, last=0, then assert rst for one cycle. Then send P=S=D=00, R=00, last=1 -> out_known=01, out_mode=00, no conflict.

Source files
------------

// File: rtl/rop3_mode_infer.sv
// Recovers the 8-bit ROP3 truth table from streamed (P,S,D,Result) samples.
// Each bit lane votes into one truth-table entry; a frame ends in a held report.

module rop3_lane_dec (
  input  logic       i_p,
  input  logic       i_s,
  input  logic       i_d,
  input  logic       i_r,
  output logic [7:0] o_seen0,
  output logic [7:0] o_seen1
);
  logic [2:0] w_idx;
  assign w_idx = {i_p, i_s, i_d};

  always_comb begin
    o_seen0        = '0;
    o_seen1        = '0;
    o_seen1[w_idx] = i_r;
    o_seen0[w_idx] = ~i_r;
  end
endmodule

module rop3_mode_infer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [N-1:0] P,
  input  logic [N-1:0] S,
  input  logic [N-1:0] D,
  input  logic [N-1:0] R,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_mode,
  output logic [7:0]   out_known,
  output logic         out_conflict,
  output logic         out_supported
);
  typedef enum logic {ST_ACC, ST_REPORT} state_t;

  state_t     r_state, w_state_nx;
  logic [7:0] r_known, r_val;
  logic       r_conflict;
  logic [7:0] r_out_mode, r_out_known;
  logic       r_out_conflict, r_out_supported;

  logic [N-1:0][7:0] w_lane_s0, w_lane_s1;
  logic [7:0]        w_seen0, w_seen1;
  logic [7:0]        w_known_nx, w_val_nx;
  logic              w_conf_nx, w_accept, w_release;

  for (genvar g = 0; g < N; g++) begin : g_lane
    rop3_lane_dec u_lane (
      .i_p     (P[g]),
      .i_s     (S[g]),
      .i_d     (D[g]),
      .i_r     (R[g]),
      .o_seen0 (w_lane_s0[g]),
      .o_seen1 (w_lane_s1[g])
    );
  end

  always_comb begin
    w_seen0 = '0;
    w_seen1 = '0;
    for (int i = 0; i < N; i++) begin
      w_seen0 = w_seen0 | w_lane_s0[i];
      w_seen1 = w_seen1 | w_lane_s1[i];
    end
  end

  // First observation of an entry wins; later disagreement only raises conflict.
  assign w_known_nx = r_known | w_seen0 | w_seen1;
  assign w_val_nx   = (r_known & r_val) | (~r_known & w_seen1);
  assign w_conf_nx  = r_conflict |
                      (|((w_seen0 & w_seen1) |
                         (r_known & r_val & w_seen0) |
                         (r_known & ~r_val & w_seen1)));

  function automatic logic is_supported(input logic [7:0] m);
    case (m)
      8'h00, 8'h11, 8'h33, 8'h44, 8'h55, 8'h5A, 8'h66, 8'h88,
      8'hBB, 8'hC0, 8'hCC, 8'hEE, 8'hF0, 8'hFB, 8'hFF: is_supported = 1'b1;
      default:                                         is_supported = 1'b0;
    endcase
  endfunction

  assign in_ready  = (r_state == ST_ACC);
  assign out_valid = (r_state == ST_REPORT);
  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_ACC:    if (w_accept && in_last) w_state_nx = ST_REPORT;
      ST_REPORT: if (w_release)           w_state_nx = ST_ACC;
      default:                            w_state_nx = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACC;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_known         <= '0;
      r_val           <= '0;
      r_conflict      <= 1'b0;
      r_out_mode      <= '0;
      r_out_known     <= '0;
      r_out_conflict  <= 1'b0;
      r_out_supported <= 1'b0;
    end else if (w_accept) begin
      r_known    <= w_known_nx;
      r_val      <= w_val_nx;
      r_conflict <= w_conf_nx;
      if (in_last) begin
        r_out_mode      <= w_val_nx & w_known_nx;
        r_out_known     <= w_known_nx;
        r_out_conflict  <= w_conf_nx;
        r_out_supported <= (w_known_nx == 8'hFF) & ~w_conf_nx &
                           is_supported(w_val_nx & w_known_nx);
      end
    end else if (w_release) begin
      r_known    <= '0;
      r_val      <= '0;
      r_conflict <= 1'b0;
    end
  end

  assign out_mode      = r_out_mode;
  assign out_known     = r_out_known;
  assign out_conflict  = r_out_conflict;
  assign out_supported = r_out_supported;
endmodule

// File: tb/tb_rop3_mode_infer.sv
// Directed bench for rop3_mode_infer: single-beat table plus multi-beat corner sequences.

module tb_rop3_mode_infer;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [7:0] P, S, D, R, out_mode, out_known;
  logic       out_conflict, out_supported;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rop3_mode_infer #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .P(P), .S(S), .D(D), .R(R), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_known(out_known), .out_conflict(out_conflict),
    .out_supported(out_supported)
  );

  typedef struct {
    logic [7:0] p, s, d, r;
    logic [7:0] mode, known;
    logic       conf, sup;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until accepted (bounded wait).
  task automatic beat(input logic [7:0] p, s, d, r, input logic last);
    int n = 0;
    P = p; S = s; D = d; R = r; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL beat_timeout: in_ready stuck 0 expected 1");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic report(input string name, input logic [7:0] mode, known,
                        input logic conf, sup);
    chk({name, ".valid"}, out_valid, 1);
    chk({name, ".mode"},  out_mode, mode);
    chk({name, ".known"}, out_known, known);
    chk({name, ".conf"},  out_conflict, conf);
    chk({name, ".sup"},   out_supported, sup);
  endtask

  task automatic release_report(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, ".rel_valid"}, out_valid, 0);
    chk({name, ".rel_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    P = '0; S = '0; D = '0; R = '0;

    // P=F0,S=CC,D=AA makes bit i index entry i, so mode == R.
    // P=0F,S=33,D=55 reverses it: entry k comes from R[7-k].
    tbl[0] = '{8'hF0, 8'hCC, 8'hAA, 8'h5A, 8'h5A, 8'hFF, 1'b0, 1'b1};
    tbl[1] = '{8'hF0, 8'hCC, 8'hAA, 8'h3C, 8'h3C, 8'hFF, 1'b0, 1'b0};
    tbl[2] = '{8'hF0, 8'hCC, 8'hAA, 8'hC0, 8'hC0, 8'hFF, 1'b0, 1'b1};
    tbl[3] = '{8'hF0, 8'hCC, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1};
    tbl[4] = '{8'hF0, 8'hCC, 8'hAA, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h01, 8'h01, 1'b1, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h40, 8'h40, 1'b0, 1'b0};
    tbl[8] = '{8'h0F, 8'h33, 8'h55, 8'h01, 8'h80, 8'hFF, 1'b0, 1'b0};
    tbl[9] = '{8'h0F, 8'h33, 8'h55, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b1};

    tick(); tick();
    rst = 1'b0;
    chk("rst.in_ready",  in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.mode",      out_mode, 0);
    chk("rst.known",     out_known, 0);
    chk("rst.conf",      out_conflict, 0);
    chk("rst.sup",       out_supported, 0);

    for (int i = 0; i < 10; i++) begin
      beat(tbl[i].p, tbl[i].s, tbl[i].d, tbl[i].r, 1'b1);
      chk($sformatf("tbl%0d.in_ready", i), in_ready, 0);
      report($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].known, tbl[i].conf, tbl[i].sup);
      release_report($sformatf("tbl%0d", i));
    end

    // Two-beat frame completes an otherwise partial table.
    beat(8'hF0, 8'hCC, 8'hAA, 8'h88, 1'b0);
    chk("seq3.mid_valid", out_valid, 0);
    beat(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    report("seq3", 8'h88, 8'hFF, 1'b0, 1'b1);
    release_report("seq3");

    // Cross-beat contradiction on entry 0; first-seen value 0 is kept.
    beat(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    beat(8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    report("seq4", 8'h00, 8'h01, 1'b1, 1'b0);
    release_report("seq4");

    // Backpressure: report held while a new beat waits.
    beat(8'hF0, 8'hCC, 8'hAA, 8'h5A, 1'b1);
    P = 8'h00; S = 8'h00; D = 8'h00; R = 8'h00; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d.in_ready", c), in_ready, 0);
      report($sformatf("bp%0d", c), 8'h5A, 8'hFF, 1'b0, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.rel_valid", out_valid, 0);
    chk("bp.rel_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    report("bp.held", 8'h00, 8'h01, 1'b0, 1'b0);
    release_report("bp.held");

    // Reset mid-frame drops the partial table; beat offered during reset is ignored.
    beat(8'hF0, 8'hCC, 8'hAA, 8'hFF, 1'b0);
    rst = 1'b1;
    P = 8'h00; S = 8'h00; D = 8'h00; R = 8'h00; in_last = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst6.out_valid", out_valid, 0);
    chk("rst6.in_ready",  in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    report("rst6", 8'h00, 8'h01, 1'b0, 1'b0);
    release_report("rst6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
